qpmm_sched: RTL
===============

QPMM_SCHED -- requirements
Module: qpmm_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters.
REQ-002 SHALL have parameter W, default 256: operand/result width in bits.
REQ-003 SHALL have parameter LAT, default 40: fixed latency of the downstream QPMM pipeline, mul_a/mul_b to mul_z.
REQ-004 SHALL have parameter DEPTH, default 64: result FIFO depth; DEPTH >= LAT+2 is required for full throughput.
REQ-005 SHALL have parameter TAGW, default 4: requester tag width.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req_valid  in  NREQ  per-requester operation valid.
REQ-009 req_ready  out  NREQ  per-requester grant/accept.
REQ-010 req_a, req_b  in  NREQ x W  operands.
REQ-011 req_tag  in  NREQ x TAGW  opaque tag returned with the result.
REQ-012 mul_a, mul_b  out  W  registered operands to the QPMM pipeline.
REQ-013 mul_z  in  W  QPMM result, valid LAT cycles after the matching mul_a/mul_b.
REQ-014 rsp_valid  out  1; rsp_ready  in  1: result handshake.
REQ-015 rsp_id  out  clog2(NREQ)  originating requester; rsp_tag  out  TAGW; rsp_z  out  W.
REQ-016 idle  out  1  high when nothing is in flight and the FIFO is empty.

Function
REQ-017 Accept: at most one request per cycle; req_ready[i] is high only for the granted i, only when req_valid[i] is high and credits > 0.
REQ-018 Arbitration: round-robin; the pointer advances to (granted+1) mod NREQ after each accept and holds otherwise.
REQ-019 Issue: on accept at edge t, mul_a/mul_b are loaded at t, and an issue-valid bit with {id, tag} enters an LAT-stage shift register.
REQ-020 mul_a/mul_b SHALL hold their last value when no accept occurs; the pipeline is free-running with no stall.
REQ-021 Capture: when the shift register output valid is high, mul_z with its {id, tag} SHALL be written to the FIFO on that edge.
REQ-022 Latency: with an empty FIFO, rsp_valid SHALL rise exactly LAT+1 cycles after the accept edge.
REQ-023 Credits: the counter starts at DEPTH; decrement on accept, increment on rsp pop; when both occur in the same cycle it is unchanged.
REQ-024 The credit counter SHALL never exceed DEPTH or go below 0, so a FIFO write never meets a full FIFO.
REQ-025 When credits == 0, all req_ready SHALL be low; requests wait and are not dropped.
REQ-026 The FIFO SHALL support a simultaneous write and pop; the read/write pointers wrap modulo DEPTH.
REQ-027 rsp outputs SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-028 Results SHALL be returned in issue order.

Reset
REQ-029 On rst: req_ready=0, rsp_valid=0, idle=1, mul_a=mul_b=0, shift register valids cleared, FIFO pointers=0, credits=DEPTH, RR pointer=0.
REQ-030 Reset mid-operation discards all in-flight and buffered results.
REQ-031 mul_z values emerging after reset from operations issued before reset SHALL be ignored.

Configuration
REQ-032 Macro QPMM_SCHED_PRIO_EN defined: requester 0 has strict priority over all others; requesters 1..NREQ-1 are round-robin among themselves.
REQ-033 Macro QPMM_SCHED_PRIO_EN undefined: pure round-robin across all NREQ requesters.

Verification
REQ-034 Single op: LAT=40, NREQ=4, req_valid[2]=1, tag=5, rsp_ready=1 -> req_ready[2] pulses once; rsp_valid rises 41 cycles after accept with rsp_id=2, rsp_tag=5, rsp_z=model(a,b).
REQ-035 Fairness (macro undefined): all four requesters valid continuously for 16 cycles -> grants in order 0,1,2,3,0,... with one accept per cycle and 16 in-order results.
REQ-036 Backpressure: DEPTH=64, rsp_ready=0, continuous requests -> exactly 64 accepts, then req_ready=0; one rsp_ready pulse -> exactly one further accept.
REQ-037 Simultaneous pop and accept with credits=1 -> credits remain 1; no overflow; FIFO wraps past index 63 with data intact.
REQ-038 Reset with 10 ops in flight -> rsp_valid=0 and idle=1 immediately; no stale result appears within LAT+5 cycles after reset release.
REQ-039 Priority (macro defined): requesters 0 and 3 continuously valid -> requester 0 wins every cycle; requester 3 is granted only once requester 0 deasserts.

Source files
------------

// File: rtl/qpmm_sched.sv
// qpmm_sched: round-robin requester arbiter feeding a fixed-LAT QPMM pipeline; rsp_valid rises LAT+1 cycles after accept.
// Credit counter (DEPTH) stalls req_ready so the result FIFO never overflows; define QPMM_SCHED_PRIO_EN to give requester 0 strict priority.
module qpmm_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 256,
  parameter int LAT   = 40,
  parameter int DEPTH = 64,
  parameter int TAGW  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][W-1:0]    req_a,
  input  logic [NREQ-1:0][W-1:0]    req_b,
  input  logic [NREQ-1:0][TAGW-1:0] req_tag,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_b,
  input  logic [W-1:0]              mul_z,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [TAGW-1:0]           rsp_tag,
  output logic [W-1:0]              rsp_z,
  output logic                      idle
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            vld;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
  } iss_t;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
    logic [W-1:0]    z;
  } ent_t;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_id;
  logic [CW-1:0]  credits;
  logic           accept;
  logic           pop;

  iss_t           iss_pipe [LAT+1];
  ent_t           mem [DEPTH];
  ent_t           rd_ent;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fcount;
  logic           wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Search starts at the round-robin pointer and wraps modulo NREQ.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_sum = '0;
    scan_id  = '0;
`ifdef QPMM_SCHED_PRIO_EN
    if (req_valid[0]) gnt_vld = 1'b1;
`endif
    for (int off = 0; off < NREQ; off++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (scan_sum >= (IDW+1)'(NREQ)) scan_sum = scan_sum - (IDW+1)'(NREQ);
      scan_id = scan_sum[IDW-1:0];
`ifdef QPMM_SCHED_PRIO_EN
      if (!gnt_vld && (scan_id != '0) && req_valid[scan_id]) begin
`else
      if (!gnt_vld && req_valid[scan_id]) begin
`endif
        gnt_vld = 1'b1;
        gnt_id  = scan_id;
      end
    end
  end

  assign accept = gnt_vld && (credits != '0) && !rst;
  assign pop    = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      credits <= CW'(DEPTH);
    end else begin
      if (accept) begin
        rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        mul_a  <= req_a[gnt_id];
        mul_b  <= req_b[gnt_id];
      end
      if (accept && !pop)      credits <= credits - 1'b1;
      else if (pop && !accept) credits <= credits + 1'b1;
    end
  end

  // One extra stage over LAT: the issue register aligns with mul_a/mul_b, the rest with mul_z.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) iss_pipe[k] <= '0;
    end else begin
      iss_pipe[0] <= {accept, gnt_id, req_tag[gnt_id]};
      for (int k = 1; k <= LAT; k++) iss_pipe[k] <= iss_pipe[k-1];
    end
  end

  assign wr = iss_pipe[LAT].vld;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {iss_pipe[LAT].id, iss_pipe[LAT].tag, mul_z};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (wr)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (wr && !pop)      fcount <= fcount + 1'b1;
      else if (pop && !wr) fcount <= fcount - 1'b1;
    end
  end

  assign rd_ent    = mem[rd_ptr];
  assign rsp_valid = (fcount != '0);
  assign rsp_id    = rd_ent.id;
  assign rsp_tag   = rd_ent.tag;
  assign rsp_z     = rd_ent.z;
  // Full credits means nothing issued, in the pipe, or buffered.
  assign idle      = (credits == CW'(DEPTH));

endmodule
